// File: rtl/mat_pkg.sv
// mat_pkg: Q16.16 format constants and lane helper shared by the dot-product datapath
package mat_pkg;
  localparam int DATA_W = 32;
  localparam int FRAC_BITS = 16;
  localparam int VEC_W = 128;
  localparam int LANES = 4;
  localparam int PROD_W = 48;
  localparam int SUM_W = 50;
  localparam logic [DATA_W-1:0] FX_ONE = 32'h0001_0000;
  localparam logic [DATA_W-1:0] FX_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] FX_MIN = 32'h8000_0000;
  // Lane 0 sits in the most significant word of the packed vector
  function automatic logic [DATA_W-1:0] lane(input logic [VEC_W-1:0] v, input int i);
    return v[VEC_W-1-i*DATA_W -: DATA_W];
  endfunction
endpackage

// File: rtl/fx_mul.sv
// fx_mul: registered signed Q-format multiply of one lane, keeping 48 bits after the fractional shift
module fx_mul
  import mat_pkg::*;
(
  input  logic                     clk,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  output logic signed [PROD_W-1:0] p
);
  logic signed [2*DATA_W-1:0] full;
  assign full = x * y;
  // Dropping the low FRAC_BITS is an arithmetic shift, so rounding is toward -inf
  always_ff @(posedge clk)
    if (en) p <= full[2*DATA_W-1:FRAC_BITS];
endmodule

// File: rtl/matrix_row_comp_unit.sv
// matrix_row_comp_unit: 2-cycle pipelined 4-lane Q16.16 dot product; define MATRIX_ROW_COMP_SAT_EN to saturate on overflow
module matrix_row_comp_unit
  import mat_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [VEC_W-1:0]  a,
  input  logic [VEC_W-1:0]  b,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);
  logic signed [PROD_W-1:0] p [LANES];
  logic                     v1;
  logic signed [SUM_W-1:0]  s;
  logic                     ovf_c;
  logic [DATA_W-1:0]        res_c;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fx_mul u_mul (
      .clk(clk),
      .en (in_valid),
      .x  (lane(a, i)),
      .y  (lane(b, i)),
      .p  (p[i])
    );
  end
  // Sum the widened products; overflow when the bits above bit 30 are not a pure sign extension
  always_comb begin
    s = SUM_W'(p[0]) + SUM_W'(p[1]) + SUM_W'(p[2]) + SUM_W'(p[3]);
    ovf_c = !(&s[SUM_W-1:DATA_W-1] || ~|s[SUM_W-1:DATA_W-1]);
`ifdef MATRIX_ROW_COMP_SAT_EN
    res_c = ovf_c ? (s[SUM_W-1] ? FX_MIN : FX_MAX) : s[DATA_W-1:0];
`else
    res_c = s[DATA_W-1:0];
`endif
  end
  // Stage-1 valid tracks the product registers; reset drops anything in flight
  always_ff @(posedge clk)
    v1 <= rst ? 1'b0 : in_valid;
  // Output stage: result and ovf only change when a new sum arrives
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        result <= res_c;
        ovf    <= ovf_c;
      end
    end
endmodule

// File: tb/tb_matrix_row_comp_unit.sv
// tb_matrix_row_comp_unit: directed-vector self-checking bench for the row dot product
module tb_matrix_row_comp_unit;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] a = '0;
  logic [127:0] b = '0;
  logic         out_valid;
  logic [31:0]  result;
  logic         ovf;
  int checks = 0;
  int errors = 0;

  matrix_row_comp_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] x0, x1, x2, x3);
    return {x0, x1, x2, x3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input string tag, input logic [127:0] va, vb,
                      input logic [31:0] er, input logic eo);
    a = va; b = vb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    tick();
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_hold"}, result, er);
  endtask

  logic [127:0] sa [4];
  logic [127:0] sb [4];
  logic [31:0]  se [4];
  int nvalid;

  initial begin
    tick(); tick();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run1("unit", pk(32'h0001_0000, 0, 0, 0), pk(32'h0003_0000, 5, 6, 7), 32'h0003_0000, 1'b0);
    run1("sum4", pk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000),
         pk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000), 32'h000A_0000, 1'b0);
    run1("neg", pk(32'hFFFE_8000, 32'h0000_8000, 0, 0), pk(32'h0002_0000, 32'h0002_0000, 0, 0),
         32'hFFFE_0000, 1'b0);
    run1("trunc", pk(32'h0000_0001, 0, 0, 0), pk(32'hFFFF_8000, 0, 0, 0), 32'hFFFF_FFFF, 1'b0);
    run1("vec3", pk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000),
         pk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0), 32'h0006_0000, 1'b0);
`ifdef MATRIX_ROW_COMP_SAT_EN
    run1("ovf_pos", {4{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, 32'h7FFF_FFFF, 1'b1);
    run1("ovf_neg", {4{32'h8000_0000}}, {4{32'h7FFF_0000}}, 32'h8000_0000, 1'b1);
`else
    run1("ovf_pos", {4{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, 32'h0004_0000, 1'b1);
    run1("ovf_neg", {4{32'h8000_0000}}, {4{32'h7FFF_0000}}, 32'h0000_0000, 1'b1);
`endif
    run1("max_edge", pk(32'h7FFF_FFFF, 0, 0, 0), pk(32'h0001_0000, 0, 0, 0), 32'h7FFF_FFFF, 1'b0);

    sa[0] = pk(32'h0001_0000, 0, 0, 0);           sb[0] = pk(32'h0003_0000, 5, 6, 7);         se[0] = 32'h0003_0000;
    sa[1] = pk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    sb[1] = {4{32'h0001_0000}};                    se[1] = 32'h000A_0000;
    sa[2] = pk(32'hFFFE_8000, 32'h0000_8000, 0, 0); sb[2] = pk(32'h0002_0000, 32'h0002_0000, 0, 0); se[2] = 32'hFFFE_0000;
    sa[3] = {4{32'h0001_0000}};                    sb[3] = pk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0); se[3] = 32'h0006_0000;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      a = (i < 4) ? sa[i] : '0;
      b = (i < 4) ? sb[i] : '0;
      tick();
      if (i >= 1 && i <= 4) begin
        chk($sformatf("stream%0d_vld", i - 1), 32'(out_valid), 32'd1);
        chk($sformatf("stream%0d_res", i - 1), result, se[i - 1]);
      end
      if (i == 5) chk("stream_end_vld", 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = sa[i]; b = sb[i];
      rst = (i == 2);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    chk("midrst_vld", 32'(out_valid), 32'd0);
    chk("midrst_res", result, 32'd0);
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) nvalid++;
    end
    chk("midrst_none", 32'(nvalid), 32'd0);

    run1("after_rst", sa[1], sb[1], 32'h000A_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
